multicycle_ctrl: RTL

//  Main control FSM for the multi-cycle RV32I subset core (add/sub/and/or/xor/sll/srl, addi, lw, sw, beq, blt, jal).

---
 rtl/multicycle_ctrl_pkg.sv | 40 ++++
 rtl/multicycle_ctrl_timeout_cnt.sv | 27 ++
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control FSM.
// State numbering is visible on o_state, so keep it stable.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_SRC_IMM   = 2'd1;

   localparam logic [1:0] ALU_SRC_B_RS2 = 2'd0;
   localparam logic [1:0] ALU_SRC_B_IMM = 2'd1;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   function automatic logic is_legal(input logic [6:0] op);
      return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
             (op == OP_SW) || (op == OP_BR) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_timeout_cnt.sv
// Memory wait watchdog shared by FETCH and MEM; o_expired flags the
// wait cycle that brings the count up to LIMIT.
module multicycle_ctrl_timeout_cnt #(
   parameter int LIMIT = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expired
);

   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= r_cnt + W'(1);
   end

   assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle core: sequences memory, IR, PC, ALU
// and register file, keeps cycle/instret counters, traps on errors.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH   = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [31:0]          i_inst,
   input  logic                 i_branch_taken,
   input  logic                 i_mem_ready,
   output logic                 o_mem_req,
   output logic                 o_mem_we,
   output logic                 o_mem_addr_sel,
   output logic                 o_ir_we,
   output logic                 o_pc_we,
   output logic [1:0]           o_pc_src,
   output logic                 o_alu_src_a,
   output logic [1:0]           o_alu_src_b,
   output logic [1:0]           o_ALUOp,
   output logic                 o_reg_we,
   output logic [1:0]           o_wb_sel,
   output logic [2:0]           o_state,
   output logic                 o_illegal_inst,
   output logic                 o_bus_err,
   output logic [CNT_WIDTH-1:0] o_cycle_cnt,
   output logic [CNT_WIDTH-1:0] o_instret_cnt
);

   state_t                r_state, w_next;
   logic                  r_ill, r_berr;
   logic [CNT_WIDTH-1:0]  r_cycle, r_instret;
   logic                  w_retire, w_set_ill, w_set_berr, w_expired;
   logic [6:0]            w_op;
   logic                  w_unused_inst;

   assign w_op          = i_inst[6:0];
   assign w_unused_inst = ^i_inst[31:7];

   // The watchdog only runs while a request is outstanding and restarts per access.
   multicycle_ctrl_timeout_cnt #(.LIMIT(MEM_TIMEOUT)) u_tmo (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (!o_mem_req || i_mem_ready),
      .i_en      (o_mem_req && !i_mem_ready),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_FETCH;
         r_ill     <= 1'b0;
         r_berr    <= 1'b0;
         r_cycle   <= '0;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (w_set_ill)  r_ill  <= 1'b1;
         if (w_set_berr) r_berr <= 1'b1;
         if (r_state != S_TRAP) r_cycle <= r_cycle + CNT_WIDTH'(1);
         if (w_retire) r_instret <= r_instret + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      w_next         = r_state;
      w_retire       = 1'b0;
      w_set_ill      = 1'b0;
      w_set_berr     = 1'b0;
      o_mem_req      = 1'b0;
      o_mem_we       = 1'b0;
      o_mem_addr_sel = 1'b0;
      o_ir_we        = 1'b0;
      o_pc_we        = 1'b0;
      o_pc_src       = PC_SRC_PLUS4;
      o_alu_src_a    = 1'b0;
      o_alu_src_b    = ALU_SRC_B_RS2;
      o_ALUOp        = ALUOP_ADD;
      o_reg_we       = 1'b0;
      o_wb_sel       = WB_SEL_ALU;
      case (r_state)
         S_FETCH: begin
            o_mem_req = 1'b1;
            if (i_mem_ready) begin
               o_ir_we = 1'b1;
               o_pc_we = 1'b1;
               w_next  = S_DECODE;
            end else if (w_expired) begin
               w_set_berr = 1'b1;
               w_next     = S_TRAP;
            end
         end
         S_DECODE: begin
            if (is_legal(w_op)) begin
               w_next = S_EXEC;
            end else begin
               w_set_ill = 1'b1;
               w_next    = S_TRAP;
            end
         end
         S_EXEC: begin
            case (w_op)
               OP_R, OP_ADDI: begin
                  o_alu_src_a = 1'b1;
                  o_alu_src_b = (w_op == OP_ADDI) ? ALU_SRC_B_IMM : ALU_SRC_B_RS2;
                  o_ALUOp     = ALUOP_FUNCT;
                  w_next      = S_WB;
               end
               OP_LW, OP_SW: begin
                  o_alu_src_a = 1'b1;
                  o_alu_src_b = ALU_SRC_B_IMM;
                  w_next      = S_MEM;
               end
               OP_BR: begin
                  o_alu_src_a = 1'b1;
                  o_ALUOp     = ALUOP_BR;
                  o_pc_we     = i_branch_taken;
                  o_pc_src    = PC_SRC_IMM;
                  w_retire    = 1'b1;
                  w_next      = S_FETCH;
               end
               OP_JAL: begin
                  o_pc_we  = 1'b1;
                  o_pc_src = PC_SRC_IMM;
                  o_reg_we = 1'b1;
                  o_wb_sel = WB_SEL_PC4;
                  w_retire = 1'b1;
                  w_next   = S_FETCH;
               end
               // IR only changes in FETCH, so this is unreachable unless i_inst is glitched
               default: begin
                  w_set_ill = 1'b1;
                  w_next    = S_TRAP;
               end
            endcase
         end
         S_MEM: begin
            o_mem_req      = 1'b1;
            o_mem_addr_sel = 1'b1;
            o_mem_we       = (w_op == OP_SW);
            if (i_mem_ready) begin
               w_retire = (w_op == OP_SW);
               w_next   = (w_op == OP_SW) ? S_FETCH : S_WB;
            end else if (w_expired) begin
               w_set_berr = 1'b1;
               w_next     = S_TRAP;
            end
         end
         S_WB: begin
            o_reg_we = 1'b1;
            o_wb_sel = (w_op == OP_LW) ? WB_SEL_MEM : WB_SEL_ALU;
            w_retire = 1'b1;
            w_next   = S_FETCH;
         end
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_FETCH;
      endcase
      // Reset silences the bus immediately, even mid-access.
      if (i_rst) begin
         o_mem_req      = 1'b0;
         o_mem_we       = 1'b0;
         o_mem_addr_sel = 1'b0;
         o_ir_we        = 1'b0;
         o_pc_we        = 1'b0;
         o_pc_src       = PC_SRC_PLUS4;
         o_alu_src_a    = 1'b0;
         o_alu_src_b    = ALU_SRC_B_RS2;
         o_ALUOp        = ALUOP_ADD;
         o_reg_we       = 1'b0;
         o_wb_sel       = WB_SEL_ALU;
      end
   end

   assign o_state        = r_state;
   assign o_illegal_inst = r_ill;
   assign o_bus_err      = r_berr;
   assign o_cycle_cnt    = r_cycle;
   assign o_instret_cnt  = r_instret;

endmodule
